// File: rtl/phi2_sched_if.sv
// Bus-side bundle of the phi2 scheduler: run/wait-state requests in, phi2 clock,
// phase markers and wait-state status out.
interface phi2_sched_if #(
  parameter int NREQ = 4
);
  logic            run;
  logic [NREQ-1:0] wait_req;
  logic            timeout_clr;
  logic            clk_phi2;
  logic [11:0]     phi2_cycle;
  logic            phi2_rise;
  logic            phi2_fall;
  logic            addr_valid;
  logic [NREQ-1:0] wait_ack;
  logic            wait_timeout;
  logic [15:0]     stretch_count;

  modport master (
    input  run, wait_req, timeout_clr,
    output clk_phi2, phi2_cycle, phi2_rise, phi2_fall, addr_valid,
           wait_ack, wait_timeout, stretch_count
  );

  modport slave (
    output run, wait_req, timeout_clr,
    input  clk_phi2, phi2_cycle, phi2_rise, phi2_fall, addr_valid,
           wait_ack, wait_timeout, stretch_count
  );
endinterface

// File: rtl/phi2_scheduler.sv
// phi2 bus-clock sequencer: programmable low/high phases, arbitrated wait-state stretch.
// Define PHI2_SCHED_STATS_EN to build the saturating stretched-phase counter.
module phi2_scheduler #(
  parameter int LOW_CYCLES  = 12,
  parameter int HIGH_CYCLES = 12,
  parameter int ADDR_SETUP  = 4,
  parameter int MAX_WAIT    = 15,
  parameter int NREQ        = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  phi2_sched_if.master bus
);
  localparam logic [11:0] LOW_LAST       = 12'(LOW_CYCLES - 1);
  localparam logic [11:0] HIGH_LAST      = 12'(HIGH_CYCLES - 1);
  localparam logic [11:0] SETUP_IDX      = 12'(ADDR_SETUP);
  localparam logic [7:0]  WAIT_LAST      = 8'(MAX_WAIT - 1);
  localparam logic        SETUP_AT_ENTRY = (ADDR_SETUP == 0);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT} state_e;

  state_e          state_q;
  logic            clk_phi2_q;
  logic            phi2_rise_q;
  logic            phi2_fall_q;
  logic            addr_valid_q;
  logic            wait_timeout_q;
  logic [11:0]     phi2_cycle_q;
  logic [NREQ-1:0] wait_ack_q;
  logic [7:0]      wait_cnt_q;

  logic [NREQ-1:0] grant_d;
  logic [11:0]     cycle_inc_d;
  logic [11:0]     cycle_sat_d;
  logic            high_end;
  logic            enter_wait;
  logic            owner_held;
  logic            timeout_hit;
  logic            release_now;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_d = '0;
    // Scan from the top so the lowest set index is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.wait_req[i]) begin
        grant_d    = '0;
        grant_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cycle_inc_d = phi2_cycle_q + 12'd1;
    cycle_sat_d = (phi2_cycle_q == 12'hFFF) ? phi2_cycle_q : cycle_inc_d;
    high_end    = (state_q == S_HIGH) && (phi2_cycle_q == HIGH_LAST);
    enter_wait  = high_end && (|bus.wait_req);
    owner_held  = |(bus.wait_req & wait_ack_q);
    timeout_hit = (state_q == S_WAIT) && owner_held && (wait_cnt_q == WAIT_LAST);
    release_now = (high_end && !enter_wait) ||
                  ((state_q == S_WAIT) && (!owner_held || (wait_cnt_q == WAIT_LAST)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      clk_phi2_q     <= 1'b0;
      phi2_rise_q    <= 1'b0;
      phi2_fall_q    <= 1'b0;
      addr_valid_q   <= 1'b0;
      wait_timeout_q <= 1'b0;
      phi2_cycle_q   <= '0;
      wait_ack_q     <= '0;
      wait_cnt_q     <= '0;
    end else begin
      phi2_rise_q <= 1'b0;
      phi2_fall_q <= 1'b0;

      if (timeout_hit) begin
        wait_timeout_q <= 1'b1;
      end else if (bus.timeout_clr) begin
        wait_timeout_q <= 1'b0;
      end

      if (release_now) begin
        // run is only looked at here; a drop mid-phase lets the high phase finish.
        state_q      <= bus.run ? S_LOW : S_IDLE;
        clk_phi2_q   <= 1'b0;
        phi2_fall_q  <= 1'b1;
        addr_valid_q <= bus.run && SETUP_AT_ENTRY;
        wait_ack_q   <= '0;
        phi2_cycle_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.run) begin
              state_q      <= S_LOW;
              phi2_cycle_q <= '0;
              addr_valid_q <= SETUP_AT_ENTRY;
            end
          end
          S_LOW: begin
            if (phi2_cycle_q == LOW_LAST) begin
              state_q      <= S_HIGH;
              clk_phi2_q   <= 1'b1;
              phi2_rise_q  <= 1'b1;
              phi2_cycle_q <= '0;
            end else begin
              phi2_cycle_q <= cycle_inc_d;
              if (cycle_inc_d == SETUP_IDX) addr_valid_q <= 1'b1;
            end
          end
          S_HIGH: begin
            if (enter_wait) begin
              state_q      <= S_WAIT;
              wait_ack_q   <= grant_d;
              wait_cnt_q   <= '0;
              phi2_cycle_q <= cycle_sat_d;
            end else begin
              phi2_cycle_q <= cycle_inc_d;
            end
          end
          S_WAIT: begin
            wait_cnt_q   <= wait_cnt_q + 8'd1;
            phi2_cycle_q <= cycle_sat_d;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PHI2_SCHED_STATS_EN
  logic [15:0] stretch_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stretch_count_q <= '0;
    end else if (enter_wait && (stretch_count_q != 16'hFFFF)) begin
      stretch_count_q <= stretch_count_q + 16'd1;
    end
  end

  assign bus.stretch_count = stretch_count_q;
`else
  assign bus.stretch_count = 16'h0000;
`endif

  assign bus.clk_phi2     = clk_phi2_q;
  assign bus.phi2_cycle   = phi2_cycle_q;
  assign bus.phi2_rise    = phi2_rise_q;
  assign bus.phi2_fall    = phi2_fall_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.wait_ack     = wait_ack_q;
  assign bus.wait_timeout = wait_timeout_q;
endmodule

// File: doc/phi2_scheduler.md
Name: phi2_scheduler

Overview:
Sequences the CPU/peripheral bus clock phi2 from the 166.67 MHz system clock with programmable low/high phase lengths.
Peripherals stretch the high phase (wait states) through a fixed-priority arbitrated request vector.
Also emits phase-edge pulses and an address-valid window for the bus decoder.
Sits between the PLL-derived system clock and the CPU bus interface; replaces free-running phi2 division.

Parameters:
LOW_CYCLES, 12, system clocks in phi2 low phase (2..4096)
HIGH_CYCLES, 12, system clocks in nominal phi2 high phase (2..4096)
ADDR_SETUP, 4, low-phase cycle index at which addr_valid asserts (0..LOW_CYCLES-1)
MAX_WAIT, 15, maximum stretch cycles before forced release (1..255)
NREQ, 4, number of wait-state requesters

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
run  in  1  enable phi2 generation
wait_req  in  NREQ  per-requester high-phase stretch request, level
timeout_clr  in  1  clears wait_timeout
clk_phi2  out  1  bus clock, registered
phi2_cycle  out  12  system-clock count within current phase
phi2_rise  out  1  one-cycle pulse, coincident with first cycle clk_phi2=1
phi2_fall  out  1  one-cycle pulse, coincident with first cycle clk_phi2=0 after high
addr_valid  out  1  high from low-phase cycle ADDR_SETUP through end of high/wait
wait_ack  out  NREQ  one-hot owner of current stretch, 0 otherwise
wait_timeout  out  1  sticky: a stretch hit MAX_WAIT
stretch_count  out  16  stretched phases count (optional feature)

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; clk_phi2=0; phi2_cycle=0; phi2_rise, phi2_fall, addr_valid=0; wait_ack=0; wait_timeout=0; stretch_count=0. Reset mid-phase aborts immediately, with no completion of the phase.
- IDLE: clk_phi2=0, phi2_cycle=0. run=1 -> LOW, phi2_cycle=0.
- LOW: phi2_cycle increments 0..LOW_CYCLES-1. addr_valid<=1 when phi2_cycle reaches ADDR_SETUP.
  - At LOW_CYCLES-1 -> HIGH: clk_phi2<=1, phi2_rise<=1 for one cycle, phi2_cycle<=0.
- HIGH: phi2_cycle increments 0..HIGH_CYCLES-1. At HIGH_CYCLES-1:
  - If any wait_req=1 -> WAIT. wait_ack<=one-hot of lowest set index; wait counter<=0.
  - Else -> release.
- WAIT: clk_phi2 stays 1; phi2_cycle keeps incrementing, saturating at 4095. Owner is frozen and a later lower-index request does not preempt. Each cycle:
  - Owner's wait_req=0 -> release.
  - Else wait counter=MAX_WAIT-1 -> release and set wait_timeout.
  - Else increment the wait counter.
- Release (single cycle): clk_phi2<=0, phi2_fall<=1, addr_valid<=0, wait_ack<=0, phi2_cycle<=0. Next state is LOW if run=1, else IDLE.
- run is sampled only at release. Dropping run mid-phase completes the current high phase, and low-phase entry is skipped.
- Nominal phi2 period = LOW_CYCLES+HIGH_CYCLES clocks (24 -> 6.94 MHz). Each stretch adds 1..MAX_WAIT clocks.
- wait_timeout: set has priority over timeout_clr in the same cycle.
- wait_req sampled at the HIGH end only. A request arriving during LOW or early HIGH takes effect at HIGH_CYCLES-1 if still held.

Optional Feature:
PHI2_SCHED_STATS_EN:
- Defined: stretch_count increments by 1 on each HIGH->WAIT transition, saturating at 16'hFFFF. Cleared by reset only.
- Undefined: stretch_count tied to 16'h0000 and no counter logic is built.

Test Plan:
- Defaults, run=1, no wait_req -> clk_phi2 period 24 clocks, 12 low/12 high; phi2_rise and phi2_fall are single-cycle; addr_valid rises on low cycle 4.
- wait_req=4'b0110 held over HIGH end, released by bit 1 after 5 cycles -> wait_ack=4'b0010; high phase = 12+5 clocks; phi2_fall on the release cycle.
- wait_req[3] held permanently -> high phase 12+15 clocks; wait_timeout=1 and stays set; timeout_clr pulse clears it; simultaneous set+clr leaves it 1.
- run dropped at low cycle 3 -> low and high phases complete; after fall, state IDLE and clk_phi2 stays 0; run=1 restarts LOW with phi2_cycle=0.
- reset_n=0 during WAIT -> next cycle all outputs at reset values; no phi2_fall pulse generated.
- PHI2_SCHED_STATS_EN defined, 3 stretched phases -> stretch_count=3; undefined -> 0.
